// File: rtl/ram_pkg.sv
// Shared types and helpers for the parametrised scratch RAM with clear engine.
package ram_pkg;

    typedef enum logic {
        StClear = 1'b0,
        StReady = 1'b1
    } ram_state_e;

    localparam int unsigned RDW_OLD = 0;
    localparam int unsigned RDW_NEW = 1;

    function automatic int unsigned lanes(input int unsigned data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/param_ram_clr_if.sv
// Request/response bundle between a RAM client (master) and param_ram_clr (slave).
interface param_ram_clr_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 10
);
    logic                write_enable;
    logic [DATA_W/8-1:0] byte_en;
    logic                read_enable;
    logic [ADDR_W-1:0]   address;
    logic [DATA_W-1:0]   data_in;
    logic                clr_req;
    logic [DATA_W-1:0]   data_out;
    logic                data_valid;
    logic                busy;
    logic                access_err;

    modport master (
        output write_enable, byte_en, read_enable, address, data_in, clr_req,
        input  data_out, data_valid, busy, access_err
    );

    modport slave (
        input  write_enable, byte_en, read_enable, address, data_in, clr_req,
        output data_out, data_valid, busy, access_err
    );
endinterface

// File: rtl/ram_core_be.sv
// Byte-enabled single-port storage array with a registered read port and
// selectable read-during-write behaviour.
module ram_core_be
    import ram_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned DEPTH    = 1024,
    parameter int unsigned RDW_MODE = RDW_OLD
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_we,
    input  logic [lanes(DATA_W)-1:0]  i_be,
    input  logic                      i_re,
    input  logic                      i_rd_zero,
    input  logic [ADDR_W-1:0]         i_addr,
    input  logic [DATA_W-1:0]         i_wdata,
    output logic [DATA_W-1:0]         o_rdata
);
    localparam int unsigned LANES = lanes(DATA_W);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;
    logic [DATA_W-1:0] w_old;
    logic [DATA_W-1:0] w_merged;

    always_comb begin
        w_old    = r_mem[i_addr];
        w_merged = w_old;
        for (int i = 0; i < LANES; i++) begin
            if (i_be[i]) w_merged[8*i +: 8] = i_wdata[8*i +: 8];
        end
    end

    // Array is not reset; the clear engine in the top level initialises it.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (i_we && i_be[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_re) begin
            if (i_rd_zero)                         r_rdata <= '0;
            else if (RDW_MODE == RDW_NEW && i_we)  r_rdata <= w_merged;
            else                                   r_rdata <= w_old;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/param_ram_clr.sv
// Parametrised single-port RAM: clear engine FSM, access checking and the
// optional second read-pipeline stage around ram_core_be.
module param_ram_clr
    import ram_pkg::*;
#(
    parameter int unsigned       DATA_W   = 8,
    parameter int unsigned       ADDR_W   = 10,
    parameter int unsigned       DEPTH    = 1024,
    parameter int unsigned       RD_LAT   = 1,
    parameter int unsigned       RDW_MODE = RDW_OLD,
    parameter logic [DATA_W-1:0] CLR_VAL  = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    param_ram_clr_if.slave       bus
);
    localparam int unsigned       LANES     = lanes(DATA_W);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    if (DATA_W == 0 || (DATA_W % 8) != 0) begin : g_bad_data_w
        $error("param_ram_clr: DATA_W must be a non-zero multiple of 8");
    end
    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
        $error("param_ram_clr: RD_LAT must be 1 or 2");
    end
    if (DEPTH == 0 || 64'(DEPTH) > (64'd1 << ADDR_W)) begin : g_bad_depth
        $error("param_ram_clr: DEPTH must be in 1..2**ADDR_W");
    end

    ram_state_e        r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_ptr, w_ptr_nxt;
    logic              w_busy, w_clr_acc, w_in_range, w_acc_ok, w_wr, w_rd, w_err;
    logic              r_err, r_v1;
    logic              w_core_we;
    logic [LANES-1:0]  w_core_be;
    logic [ADDR_W-1:0] w_core_addr;
    logic [DATA_W-1:0] w_core_wdata, w_core_rdata;

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_busy      = (r_state == StClear);
        w_clr_acc   = 1'b0;
        unique case (r_state)
            StClear: begin
                w_ptr_nxt = r_ptr + 1'b1;
                if (r_ptr == LAST_ADDR) w_state_nxt = StReady;
            end
            StReady: begin
                if (bus.clr_req) begin
                    w_clr_acc   = 1'b1;
                    w_state_nxt = StClear;
                    w_ptr_nxt   = '0;
                end
            end
        endcase

        // A clear request wins over any access issued in the same cycle.
        w_in_range = {1'b0, bus.address} < DEPTH_EXT;
        w_acc_ok   = !w_busy && !w_clr_acc;
        w_wr       = bus.write_enable && w_acc_ok && w_in_range;
        w_rd       = bus.read_enable && w_acc_ok;
        w_err      = (bus.write_enable || bus.read_enable) && !(w_acc_ok && w_in_range);

        w_core_we    = w_busy || w_wr;
        w_core_be    = w_busy ? '1 : bus.byte_en;
        w_core_addr  = w_busy ? r_ptr : bus.address;
        w_core_wdata = w_busy ? CLR_VAL : bus.data_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StClear;
            r_ptr   <= '0;
            r_err   <= 1'b0;
            r_v1    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_err   <= w_err;
            r_v1    <= w_rd;
        end
    end

    ram_core_be #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .RDW_MODE (RDW_MODE)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_we      (w_core_we),
        .i_be      (w_core_be),
        .i_re      (w_rd),
        .i_rd_zero (!w_in_range),
        .i_addr    (w_core_addr),
        .i_wdata   (w_core_wdata),
        .o_rdata   (w_core_rdata)
    );

    if (RD_LAT == 1) begin : g_lat1
        assign bus.data_out   = w_core_rdata;
        assign bus.data_valid = r_v1;
    end else begin : g_lat2
        logic              r_v2;
        logic [DATA_W-1:0] r_dout2;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_v2    <= 1'b0;
                r_dout2 <= '0;
            end else begin
                r_v2 <= r_v1;
                if (r_v1) r_dout2 <= w_core_rdata;
            end
        end

        assign bus.data_out   = r_dout2;
        assign bus.data_valid = r_v2;
    end

    assign bus.busy       = w_busy;
    assign bus.access_err = r_err;

endmodule

// File: tb/tb_param_ram_clr.sv
// Drives two differently configured RAM instances with shared random and directed
// traffic and compares every output, every cycle, against an array-based model.
module tb_param_ram_clr;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        t_we = 1'b0, t_re = 1'b0, t_clr = 1'b0;
    logic [3:0]  t_be = '0;
    logic [9:0]  t_addr = '0;
    logic [31:0] t_din = '0;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: index 0 = instance A (32b, 1000 deep, lat 2, new-data RDW),
    //              index 1 = instance B (8b, 1024 deep, lat 1, old-data RDW).
    logic [31:0] m_mem [2][1024];
    int          m_cnt [2];
    logic        m_err [2];
    logic        m_v   [2];
    logic [31:0] m_d   [2];
    logic        m_sv  [2];
    logic [31:0] m_sd  [2];

    always #5 clk = ~clk;

    param_ram_clr_if #(.DATA_W(32), .ADDR_W(10)) if_a ();
    param_ram_clr_if #(.DATA_W(8),  .ADDR_W(10)) if_b ();

    assign if_a.write_enable = t_we;
    assign if_a.byte_en      = t_be;
    assign if_a.read_enable  = t_re;
    assign if_a.address      = t_addr;
    assign if_a.data_in      = t_din;
    assign if_a.clr_req      = t_clr;
    assign if_b.write_enable = t_we;
    assign if_b.byte_en      = t_be[0];
    assign if_b.read_enable  = t_re;
    assign if_b.address      = t_addr;
    assign if_b.data_in      = t_din[7:0];
    assign if_b.clr_req      = t_clr;

    param_ram_clr #(
        .DATA_W(32), .ADDR_W(10), .DEPTH(1000), .RD_LAT(2), .RDW_MODE(1),
        .CLR_VAL(32'h5A5A_C3C3)
    ) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_a.slave)
    );

    param_ram_clr #(
        .DATA_W(8), .ADDR_W(10), .DEPTH(1024), .RD_LAT(1), .RDW_MODE(0),
        .CLR_VAL(8'h00)
    ) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_b.slave)
    );

    function automatic int p_depth(input int k);  return (k == 0) ? 1000 : 1024; endfunction
    function automatic int p_lat(input int k);    return (k == 0) ? 2 : 1;       endfunction
    function automatic int p_lanes(input int k);  return (k == 0) ? 4 : 1;       endfunction
    function automatic bit p_rdw_new(input int k); return (k == 0);              endfunction
    function automatic logic [31:0] p_clr(input int k);
        return (k == 0) ? 32'h5A5A_C3C3 : 32'h0;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
        end
    endtask

    // A clear leaves every word at CLR_VAL and keeps the RAM busy for DEPTH cycles.
    task automatic model_start_clear(input int k);
        for (int i = 0; i < 1024; i++) m_mem[k][i] = p_clr(k);
        m_cnt[k] = p_depth(k);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            model_start_clear(k);
            m_err[k] = 1'b0;
            m_v[k]   = 1'b0;
            m_d[k]   = '0;
            m_sv[k]  = 1'b0;
            m_sd[k]  = '0;
        end
    endtask

    task automatic model_step();
        logic        inr, rd_v;
        logic [31:0] old_w, new_w, rd_d;
        for (int k = 0; k < 2; k++) begin
            inr   = (int'(t_addr) < p_depth(k));
            rd_v  = 1'b0;
            rd_d  = '0;
            old_w = '0;
            new_w = '0;
            if (m_cnt[k] != 0) begin
                m_cnt[k]--;
                m_err[k] = t_we | t_re;
            end else if (t_clr) begin
                model_start_clear(k);
                m_err[k] = t_we | t_re;
            end else begin
                m_err[k] = (t_we | t_re) & ~inr;
                if (inr) begin
                    old_w = m_mem[k][t_addr];
                    new_w = old_w;
                    for (int i = 0; i < p_lanes(k); i++)
                        if (t_be[i]) new_w[8*i +: 8] = t_din[8*i +: 8];
                    if (t_we) m_mem[k][t_addr] = new_w;
                end
                if (t_re) begin
                    rd_v = 1'b1;
                    rd_d = !inr ? 32'h0 : (p_rdw_new(k) && t_we) ? new_w : old_w;
                end
            end
            if (p_lat(k) == 1) begin
                m_v[k] = rd_v;
                if (rd_v) m_d[k] = rd_d;
            end else begin
                m_v[k] = m_sv[k];
                if (m_sv[k]) m_d[k] = m_sd[k];
                m_sv[k] = rd_v;
                m_sd[k] = rd_d;
            end
        end
    endtask

    task automatic compare_all();
        check_eq("a_busy",  32'(if_a.busy),       32'(m_cnt[0] != 0));
        check_eq("a_err",   32'(if_a.access_err), 32'(m_err[0]));
        check_eq("a_valid", 32'(if_a.data_valid), 32'(m_v[0]));
        check_eq("a_data",  if_a.data_out,        m_d[0]);
        check_eq("b_busy",  32'(if_b.busy),       32'(m_cnt[1] != 0));
        check_eq("b_err",   32'(if_b.access_err), 32'(m_err[1]));
        check_eq("b_valid", 32'(if_b.data_valid), 32'(m_v[1]));
        check_eq("b_data",  32'(if_b.data_out),   m_d[1] & 32'hFF);
    endtask

    task automatic cyc(input logic we, input logic [3:0] be, input logic re,
                       input logic [9:0] a, input logic [31:0] d, input logic clr);
        t_we = we; t_be = be; t_re = re; t_addr = a; t_din = d; t_clr = clr;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 4'h0, 1'b0, 10'd0, 32'h0, 1'b0);
    endtask

    // Bounded wait for both clear engines to finish.
    task automatic wait_ready();
        int guard = 0;
        while ((m_cnt[0] != 0 || m_cnt[1] != 0) && guard < 1100) begin
            idle(1);
            guard++;
        end
        check_eq("ready_timeout", 32'(guard < 1100), 32'd1);
    endtask

    // Asynchronous reset asserted between clock edges.
    task automatic do_reset();
        t_we = 1'b0; t_re = 1'b0; t_clr = 1'b0; t_be = '0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [9:0] ra;
        int         sel;

        model_reset();
        #3;
        compare_all();
        #19;
        rst_n = 1'b1;

        wait_ready();
        idle(2);

        // Read of cleared location, then writes and back-to-back reads.
        cyc(1'b0, 4'h0, 1'b1, 10'd55, 32'h0, 1'b0);
        idle(2);
        cyc(1'b1, 4'hF, 1'b0, 10'd55, 32'h56, 1'b0);
        cyc(1'b1, 4'hF, 1'b0, 10'd66, 32'h36, 1'b0);
        cyc(1'b0, 4'h0, 1'b1, 10'd55, 32'h0, 1'b0);
        cyc(1'b0, 4'h0, 1'b1, 10'd66, 32'h0, 1'b0);
        idle(3);

        // Byte-lane merge.
        cyc(1'b1, 4'hF, 1'b0, 10'd3, 32'hAABB_CCDD, 1'b0);
        cyc(1'b1, 4'h5, 1'b0, 10'd3, 32'h1122_3344, 1'b0);
        cyc(1'b0, 4'h0, 1'b1, 10'd3, 32'h0, 1'b0);
        idle(3);
        check_eq("merge_a", m_d[0], 32'hAA22_CC44);

        // Read during write at the same address.
        cyc(1'b1, 4'hF, 1'b0, 10'd10, 32'h55, 1'b0);
        cyc(1'b1, 4'hF, 1'b1, 10'd10, 32'h77, 1'b0);
        idle(3);

        // Clear request with a simultaneous write, then a write while busy.
        cyc(1'b1, 4'hF, 1'b0, 10'd5, 32'hDEAD_0005, 1'b0);
        cyc(1'b1, 4'hF, 1'b0, 10'd5, 32'h1234_5678, 1'b1);
        cyc(1'b1, 4'hF, 1'b1, 10'd5, 32'h8765_4321, 1'b0);
        wait_ready();
        cyc(1'b0, 4'h0, 1'b1, 10'd5, 32'h0, 1'b0);
        idle(3);

        // Out-of-range access on the 1000-deep instance.
        cyc(1'b1, 4'hF, 1'b0, 10'd1010, 32'hFFFF_FFFF, 1'b0);
        cyc(1'b0, 4'h0, 1'b1, 10'd1010, 32'h0, 1'b0);
        idle(3);

        // Reset with a read still in flight.
        cyc(1'b0, 4'h0, 1'b1, 10'd3, 32'h0, 1'b0);
        do_reset();
        idle(3);
        wait_ready();

        // Reset part-way through a requested clear.
        cyc(1'b0, 4'h0, 1'b0, 10'd0, 32'h0, 1'b1);
        idle(300);
        do_reset();
        wait_ready();

        for (int n = 0; n < 3000; n++) begin
            sel = $urandom_range(0, 7);
            ra  = (sel == 0) ? 10'($urandom_range(990, 1023)) : 10'($urandom_range(0, 15));
            cyc(1'($urandom), 4'($urandom), 1'($urandom), ra, $urandom,
                1'($urandom_range(0, 799) == 0));
        end
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
